// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and counter sizing for the uart_tx_arb slice.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACT, WAIT_BUSY, WAIT_DONE} arb_state_t;

    localparam int ACT_CYC_DEF = 2;
    localparam int TMO_DEF     = 1024;

    // One counter serves both the act hold and the busy timeout, so size it for the larger.
    function automatic int cnt_width(input int act_cyc, input int tmo);
        return $clog2((act_cyc > tmo ? act_cyc : tmo) + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(ACT_CYC_DEF, TMO_DEF);

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req after index last, wrapping mod N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] win,
    output logic         any
);

    logic [W-1:0] idx;

    // Walk from the farthest offset back to the nearest so the nearest set bit wins.
    always_comb begin
        win = '0;
        idx = '0;
        any = |req;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx]) win = idx;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin share of one UART tx between N byte requesters.
// Define UART_ARB_TIMEOUT_EN to abort a frame when tx never raises busy within TMO cycles.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int ACT_CYC = ACT_CYC_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0][7:0]    data,
    output logic [N-1:0]         ack,
    output logic [7:0]           tx_data,
    output logic                 act,
    input  logic                 busy,
    output logic [$clog2(N)-1:0] grant,
    output logic                 active,
    output logic                 done,
    output logic                 tmo_err
);

    localparam int W  = $clog2(N);
    localparam int CW = cnt_width(ACT_CYC, TMO);

    arb_state_t    state_q, state_d;
    logic [W-1:0]  last_q, last_d, grant_q, grant_d, win;
    logic [7:0]    tx_q, tx_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          act_q, act_d, active_q, active_d, done_q, done_d;
    logic          tmo_q, tmo_d, seen_q, seen_d, any;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        tx_d     = tx_q;
        ack_d    = '0;
        act_d    = act_q;
        active_d = active_q;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (any) begin
                tx_d       = data[win];
                grant_d    = win;
                ack_d[win] = 1'b1;
                active_d   = 1'b1;
                act_d      = 1'b1;
                cnt_d      = '0;
                seen_d     = 1'b0;
                state_d    = ACT;
            end
            ACT: begin
                // tx may raise busy while act is still high; remember it for WAIT_BUSY.
                seen_d = seen_q | busy;
                if (cnt_q == CW'(ACT_CYC - 1)) begin
                    act_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (busy || seen_q) state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TMO - 1)) begin
                    tmo_d    = 1'b1;
                    active_d = 1'b0;
                    last_d   = grant_q;
                    state_d  = IDLE;
                end else cnt_d = cnt_q + 1'b1;
`endif
            end
            WAIT_DONE: if (!busy) begin
                done_d   = 1'b1;
                active_d = 1'b0;
                last_d   = grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= W'(N - 1);
            grant_q  <= '0;
            tx_q     <= '0;
            ack_q    <= '0;
            act_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            tx_q     <= tx_d;
            ack_q    <= ack_d;
            act_q    <= act_d;
            active_q <= active_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack     = ack_q;
    assign tx_data = tx_q;
    assign act     = act_q;
    assign grant   = grant_q;
    assign active  = active_q;
    assign done    = done_q;
    assign tmo_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: vector table plus directed sequences for uart_tx_arb (N=4, ACT_CYC=2, TMO=16).
module tb_uart_tx_arb;

    logic             clk = 1'b0;
    logic             rst, busy;
    logic [3:0]       req, ack;
    logic [3:0][7:0]  data;
    logic [7:0]       tx_data;
    logic [1:0]       grant;
    logic             act, active, done, tmo_err;
    int               checks = 0;
    int               errors = 0;

    uart_tx_arb #(.N(4), .ACT_CYC(2), .TMO(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .tx_data (tx_data),
        .act     (act),
        .busy    (busy),
        .grant   (grant),
        .active  (active),
        .done    (done),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic [3:0] ack;
        logic [7:0] txd;
        logic       act;
        logic [1:0] grant;
        logic       active;
        logic       done;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for a grant, optionally drop that req, emulate a 4-cycle tx frame, wait for done.
    task automatic serve(input bit drop, output int g);
        int k;
        k = 0;
        while (ack == 4'b0 && k < 20) begin
            tick();
            k++;
        end
        chk("ack_wait", 32'(ack != 4'b0), 1);
        chk("ack_onehot", 32'(ack), 32'(1) << grant);
        chk("tx_data", 32'(tx_data), 32'(data[grant]));
        g = int'(grant);
        if (drop) req[grant] = 1'b0;
        busy = 1'b1;
        repeat (4) tick();
        busy = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        chk("done_wait", 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g, k;
        logic extra, tmo_seen, done_seen;

        //           req      busy  ack      txd    act   grant  active done
        vt[0]  = '{4'b0010, 1'b0, 4'b0010, 8'h96, 1'b1, 2'd1, 1'b1, 1'b0};
        vt[1]  = '{4'b0000, 1'b0, 4'b0000, 8'h96, 1'b1, 2'd1, 1'b1, 1'b0};
        vt[2]  = '{4'b0000, 1'b0, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b1, 1'b0};
        vt[3]  = '{4'b0000, 1'b0, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b1, 1'b0};
        vt[4]  = '{4'b0000, 1'b1, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b1, 1'b0};
        vt[5]  = '{4'b0000, 1'b1, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b1, 1'b0};
        vt[6]  = '{4'b0100, 1'b1, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b1, 1'b0};
        vt[7]  = '{4'b0000, 1'b0, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b0, 1'b1};
        vt[8]  = '{4'b0000, 1'b0, 4'b0000, 8'h96, 1'b0, 2'd1, 1'b0, 1'b0};
        vt[9]  = '{4'b1001, 1'b0, 4'b1000, 8'hA3, 1'b1, 2'd3, 1'b1, 1'b0};
        vt[10] = '{4'b0001, 1'b1, 4'b0000, 8'hA3, 1'b1, 2'd3, 1'b1, 1'b0};
        vt[11] = '{4'b0001, 1'b0, 4'b0000, 8'hA3, 1'b0, 2'd3, 1'b1, 1'b0};
        vt[12] = '{4'b0001, 1'b0, 4'b0000, 8'hA3, 1'b0, 2'd3, 1'b1, 1'b0};
        vt[13] = '{4'b0001, 1'b0, 4'b0000, 8'hA3, 1'b0, 2'd3, 1'b0, 1'b1};
        vt[14] = '{4'b0001, 1'b0, 4'b0001, 8'hA0, 1'b1, 2'd0, 1'b1, 1'b0};
        vt[15] = '{4'b0000, 1'b1, 4'b0000, 8'hA0, 1'b1, 2'd0, 1'b1, 1'b0};
        vt[16] = '{4'b0000, 1'b0, 4'b0000, 8'hA0, 1'b0, 2'd0, 1'b1, 1'b0};
        vt[17] = '{4'b0000, 1'b0, 4'b0000, 8'hA0, 1'b0, 2'd0, 1'b1, 1'b0};
        vt[18] = '{4'b0000, 1'b0, 4'b0000, 8'hA0, 1'b0, 2'd0, 1'b0, 1'b1};

        rst  = 1'b1;
        req  = 4'b0;
        busy = 1'b0;
        data = {8'hA3, 8'hA2, 8'h96, 8'hA0};
        #1;
        chk("reset_values", 32'({ack, tx_data, act, grant, active, done, tmo_err}), 0);
        repeat (2) tick();
        rst = 1'b0;

        // Single byte from req[1], busy seen only after act, req[2] glitch during WAIT_DONE,
        // then a frame whose busy pulse lies entirely inside the act window.
        for (int i = 0; i < 19; i++) begin
            req  = vt[i].req;
            busy = vt[i].busy;
            tick();
            chk($sformatf("vec%0d", i),
                32'({ack, tx_data, act, grant, active, done, tmo_err}),
                32'({vt[i].ack, vt[i].txd, vt[i].act, vt[i].grant, vt[i].active, vt[i].done, 1'b0}));
        end

        // All four request once, each dropping after its ack.
        data[1] = 8'hA1;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve(1'b1, g);
            chk("rr_order", 32'(g), 32'(i));
        end
        extra = 1'b0;
        repeat (6) begin
            tick();
            extra = extra | (ack != 4'b0);
        end
        chk("no_extra_ack", 32'(extra), 0);

        // Two continuous requesters alternate; the others stay idle.
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, g);
            chk("alternate", 32'(g), 32'((i % 2) * 2));
        end
        req = 4'b0;
        repeat (3) tick();

        // Async reset while in WAIT_DONE.
        do_reset();
        req = 4'b0100;
        k = 0;
        while (ack == 4'b0 && k < 20) begin
            tick();
            k++;
        end
        req  = 4'b0;
        busy = 1'b1;
        repeat (3) tick();
        chk("pre_reset_state", 32'({act, active, grant}), 32'({1'b0, 1'b1, 2'd2}));
        #2 rst = 1'b1;
        #1 chk("async_reset", 32'({act, active, grant, ack, done}), 0);
        busy = 1'b0;
        req  = 4'b1001;
        #2 rst = 1'b0;
        serve(1'b1, g);
        req = 4'b0;
        chk("post_reset_first", 32'(g), 0);
        repeat (3) tick();

        // tx never raises busy.
        do_reset();
        req = 4'b0001;
        k = 0;
        while (ack == 4'b0 && k < 20) begin
            tick();
            k++;
        end
        req = 4'b0;
        k = 0;
        while (act && k < 10) begin
            tick();
            k++;
        end
        chk("act_fall", 32'(act), 0);
        k = 0;
        tmo_seen  = 1'b0;
        done_seen = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        while (!tmo_seen && k < 40) begin
            tick();
            k++;
            tmo_seen  = tmo_err;
            done_seen = done_seen | done;
        end
        chk("tmo_cycles", 32'(k), 16);
        chk("tmo_active", 32'(active), 0);
        chk("tmo_no_done", 32'(done_seen), 0);
        tick();
        chk("tmo_pulse", 32'(tmo_err), 0);
`else
        repeat (40) begin
            tick();
            tmo_seen  = tmo_seen | tmo_err;
            done_seen = done_seen | done;
        end
        chk("no_tmo", 32'(tmo_seen), 0);
        chk("still_waiting", 32'({active, done_seen}), 32'({1'b1, 1'b0}));
        busy = 1'b1;
        repeat (2) tick();
        busy = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        chk("late_busy_done", 32'(done), 1);
`endif
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
